gpio_change_capture: RTL

Change-detecting event recorder that consumes the 32-bit GPIO input word stream emitted by the GPIO AXI-Stream bridge. It compares each accepted sample against the previous one under a programmable mask. On a change it pushes a timestamped event into an internal FIFO, which drains to an AXI-Stream master toward the host DMA. Overflow is reported via a sticky flag and a drop counter.

---
 rtl/gpio_change_capture.sv | 119 +++++++++++
 1 files changed

// File: rtl/gpio_change_capture.sv
// gpio_change_capture: masked change detector on a GPIO sample stream.
// Changed samples are stamped with a free-running timestamp and queued in a
// circular FIFO that drains to an AXI-Stream master. Events arriving at a full
// FIFO are dropped and counted.
module gpio_change_capture #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             mask,
  input  logic                          ovf_clear,
  output logic [TS_W+DATA_W-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned EW       = TS_W + DATA_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic [TS_W-1:0]   r_ts;
  logic [DATA_W-1:0] r_prev;
  logic              r_primed;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              r_overflow;
  logic [15:0]       r_drop_count;

  logic [AW:0]       w_level;
  logic              w_full;
  logic              w_valid;
  logic              w_change;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;

  // Pointers carry an extra wrap bit, so their difference is the occupancy.
  assign w_level  = r_wptr - r_rptr;
  assign w_full   = (w_level == FULL_LVL);
  assign w_valid  = (w_level != '0);
  assign w_change = s_axis_tvalid & enable & r_primed &
                    (|((s_axis_tdata ^ r_prev) & mask));
  // A full FIFO drops the event even if a pop frees a slot this cycle.
  assign w_push   = w_change & ~w_full;
  assign w_drop   = w_change & w_full;
  assign w_pop    = w_valid & m_axis_tready;

  assign s_axis_tready = 1'b1;
  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_valid ? r_mem[r_rptr[AW-1:0]] : '0;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;
  assign fifo_level    = w_level;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // Reference sample tracking; enable low forces the next sample to re-prime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else if (!enable) begin
      r_primed <= 1'b0;
    end else if (s_axis_tvalid) begin
      r_prev   <= s_axis_tdata;
      r_primed <= 1'b1;
    end
  end

  // Event storage; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {r_ts, s_axis_tdata};
    end
  end

  // Circular buffer read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Overflow bookkeeping; a drop in the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (ovf_clear) begin
      r_overflow   <= w_drop;
      r_drop_count <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != '1) r_drop_count <= r_drop_count + 16'd1;
    end
  end

endmodule
